// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin front end for one shared, fixed-latency,
// non-stallable float32 unit. It grants at most one requester per cycle,
// registers the operand into the unit, and carries the owner id alongside the
// operation so each result comes back tagged with the requester that issued it.
module fp_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DW      = 32,
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                u_valid,
    output logic [DW-1:0]       u_in,
    input  logic [DW-1:0]       u_out,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [DW-1:0]       res_data,
    output logic                busy
);

    localparam int CW = $clog2(LATENCY + 2);

    logic [IDW-1:0]              rr_ptr;
    logic [IDW-1:0]              gnt_id;
    logic                        gnt_found;
    logic [NREQ-1:0]             hi_req;
    logic [DW-1:0]               sel_data;
    logic [IDW-1:0]              nxt_ptr;

    // Entry 0 is loaded on the same edge as u_valid; the remaining LATENCY
    // entries track the operation through the unit, so the last entry lines up
    // with the unit's result.
    logic [LATENCY:0]            vld_pipe;
    logic [LATENCY:0][IDW-1:0]   id_pipe;
    logic [CW-1:0]               in_flight;

    // Round-robin search starting at rr_ptr: prefer the lowest valid index at
    // or above the pointer, otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_req    = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NREQ; k++)
            hi_req[k] = req_valid[k] && (k >= int'(rr_ptr));
        if (en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k]) begin
                    gnt_found = 1'b1;
                    gnt_id    = IDW'(k);
                end
            end
            if (|hi_req) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (hi_req[k]) gnt_id = IDW'(k);
            end
        end
    end

    // One-hot grant; a grant is only raised on a valid request, so a grant is
    // a transfer.
    always_comb begin
        req_ready = '0;
        if (gnt_found) req_ready = NREQ'(1) << gnt_id;
    end

    // Operand mux for the granted requester and the pointer that follows it.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++)
            if (gnt_id == IDW'(k)) sel_data = req_data[k*DW +: DW];
        nxt_ptr = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    // Issue register into the unit; u_in keeps its last operand when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_valid <= 1'b0;
            u_in    <= '0;
            rr_ptr  <= '0;
        end else begin
            u_valid <= gnt_found;
            if (gnt_found) begin
                u_in   <= sel_data;
                rr_ptr <= nxt_ptr;
            end
        end
    end

    // Tag pipe: advances every cycle because the unit never stalls. Clearing
    // it on reset drops any results still inside the unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:0], gnt_found};
            id_pipe  <= {id_pipe[LATENCY-1:0], (gnt_found ? gnt_id : IDW'(0))};
        end
    end

    // Outstanding-operation count: issued but not yet returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({gnt_found, res_valid})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign res_valid = vld_pipe[LATENCY];
    assign res_id    = id_pipe[LATENCY];
    assign res_data  = u_out;
    assign busy      = (in_flight != '0);

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with the shared unit modelled as a plain
// four-cycle delay line on u_in.
module tb_fp_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 32;
    localparam int LAT  = 4;

    logic                clk;
    logic                rst;
    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                u_valid;
    logic [DW-1:0]       u_in;
    logic [DW-1:0]       u_out;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [DW-1:0]       res_data;
    logic                busy;

    fp_unit_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .u_valid(u_valid), .u_in(u_in), .u_out(u_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // unit model: result = operand, LAT cycles after u_valid
    logic [DW-1:0] dly [LAT];
    always @(posedge clk) begin
        dly[0] <= u_in;
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign u_out = dly[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int peak   = 0;
    int          gnt_q  [$];
    int          rid_q  [$];
    logic [31:0] rdat_q [$];
    int          rcyc_q [$];

    logic [31:0] ftbl [10] = '{32'h00000000, 32'h3F800000, 32'h40000000,
        32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000,
        32'h40E00000, 32'h41000000, 32'h41100000};

    always @(posedge clk) cyc_n++;

    // log grants, results and in-flight peak at the quiet edge
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NREQ; k++)
                if (req_ready[k]) gnt_q.push_back(k);
            if (res_valid) begin
                rid_q.push_back(int'(res_id));
                rdat_q.push_back(res_data);
                rcyc_q.push_back(cyc_n);
            end
            if (int'(dut.in_flight) > peak) peak = int'(dut.in_flight);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        gnt_q.delete();
        rid_q.delete();
        rdat_q.delete();
        rcyc_q.delete();
        peak = 0;
    endtask

    task automatic rst_pulse();
        req_valid = '0;
        en        = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        clr_logs();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("drain", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;

        // reset state
        @(negedge clk);
        chk("rst_u_valid", u_valid, 0);
        chk("rst_u_in", u_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        en  = 1'b1;
        step();

        // single request: ready at t, issue at t+1, result at t+5
        req_valid = 4'b0001;
        req_data[31:0] = 32'h3F800000;
        @(negedge clk);
        chk("t0_ready", req_ready, 4'b0001);
        chk("t0_busy", busy, 0);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_u_valid", u_valid, 1);
        chk("t1_u_in", u_in, 32'h3F800000);
        chk("t1_busy", busy, 1);
        for (int j = 2; j <= 4; j++) begin
            step();
            @(negedge clk);
            chk("tmid_res_valid", res_valid, 0);
            chk("tmid_busy", busy, 1);
        end
        step();
        @(negedge clk);
        chk("t5_res_valid", res_valid, 1);
        chk("t5_res_id", res_id, 0);
        chk("t5_res_data", res_data, 32'h3F800000);
        chk("t5_busy", busy, 1);
        step();
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_res_valid", res_valid, 0);

        // fairness: all four valid for 8 cycles
        rst_pulse();
        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = 32'h1000 + k;
        req_valid = 4'hF;
        repeat (8) step();
        req_valid = '0;
        drain();
        chk("fair_ngnt", gnt_q.size(), 8);
        chk("fair_nres", rid_q.size(), 8);
        for (int i = 0; i < 8 && i < gnt_q.size(); i++) chk("fair_gnt", gnt_q[i], i % 4);
        for (int i = 0; i < 8 && i < rid_q.size(); i++) begin
            chk("fair_id", rid_q[i], i % 4);
            chk("fair_data", rdat_q[i], 32'h1000 + (i % 4));
        end
        if (rcyc_q.size() == 8) chk("fair_nogap", rcyc_q[7] - rcyc_q[0], 7);
        chk("fair_peak", peak, 5);

        // skip idle requesters
        rst_pulse();
        req_valid = 4'b1010;
        repeat (4) step();
        req_valid = '0;
        drain();
        chk("skip_ngnt", gnt_q.size(), 4);
        for (int i = 0; i < 4 && i < gnt_q.size(); i++) chk("skip_gnt", gnt_q[i], (i % 2) ? 3 : 1);

        // float stream on requester 2
        rst_pulse();
        for (int i = 0; i < 10; i++) begin
            req_data[2*DW +: DW] = ftbl[i];
            req_valid = 4'b0100;
            step();
        end
        req_valid = '0;
        drain();
        chk("flt_nres", rid_q.size(), 10);
        for (int i = 0; i < 10 && i < rid_q.size(); i++) begin
            chk("flt_id", rid_q[i], 2);
            chk("flt_data", rdat_q[i], ftbl[i]);
        end
        if (rcyc_q.size() == 10) chk("flt_nogap", rcyc_q[9] - rcyc_q[0], 9);

        // en dropped after three transfers
        rst_pulse();
        req_valid = 4'hF;
        for (int j = 0; j < 12; j++) begin
            en = (j < 3);
            @(negedge clk);
            if (j >= 3) chk("en0_ready", req_ready, 0);
            if (j == 7) chk("en0_busy_last", busy, 1);
            if (j == 8) chk("en0_busy_fall", busy, 0);
            step();
        end
        chk("en0_nres", rid_q.size(), 3);
        for (int i = 0; i < 3 && i < rid_q.size(); i++) chk("en0_id", rid_q[i], i);
        en = 1'b1;
        #1;
        chk("en1_resume", req_ready, 4'b1000);

        // async reset with three operations outstanding
        rst_pulse();
        req_valid = 4'hF;
        repeat (3) step();
        req_valid = '0;
        #2;
        chk("pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_u_valid", u_valid, 0);
        chk("arst_u_in", u_in, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_id", res_id, 0);
        chk("arst_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        clr_logs();
        repeat (12) step();
        chk("arst_nres", rid_q.size(), 0);
        chk("arst_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Round-robin arbiter that shares one fixed-latency, non-stallable float32 datapath unit (the mod_top-style operator: one 32-bit operand in, one 32-bit result out) among NREQ requesters.
- Accepts operands through per-requester valid/ready handshakes and issues at most one operand per cycle to the unit.
- Tracks each issued operand's requester id through a tag pipeline matched to the unit latency, so every result returns tagged with its owner.
- Sits between the testbench/PLI stimulus sources and the shared unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ.
- DW, 32, operand/result width (float32).
- LATENCY, 4, unit latency in cycles from u_valid to the matching u_out (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  grant enable; 0 blocks new grants, in-flight operations still complete.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*DW  requester k operand on bits [k*DW +: DW].
- req_ready  out  NREQ  one-hot grant; at most one bit set per cycle.
- u_valid  out  1  registered issue strobe to the unit.
- u_in  out  DW  registered operand to the unit (mapped to i_in).
- u_out  in  DW  unit result (mapped to o_out); valid LATENCY cycles after u_valid.
- res_valid  out  1  result strobe.
- res_id  out  IDW  requester id owning the result.
- res_data  out  DW  result value; equals u_out combinationally.
- busy  out  1  high while any operation is issued or in flight.

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0.
  - u_valid=0, u_in=0.
  - tag pipe cleared, so res_valid=0 and res_id=0.
  - in_flight=0, busy=0.
  - Results already inside the unit are discarded; no res_valid is produced for them after reset releases.
- Grant (combinational):
  - If en=1, search k = rr_ptr, rr_ptr+1, ... (mod NREQ) and take the first k with req_valid[k]=1.
  - req_ready[k]=1 for that k only; all other bits 0. All bits 0 if en=0 or no request is valid.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer: a transfer occurs when req_valid[g] & req_ready[g]. On that posedge:
  - u_valid<=1, u_in<=req_data[g].
  - the tag pipe entry 0 captures {1,g}.
  - rr_ptr<=(g+1) mod NREQ.
- With no transfer: u_valid<=0, u_in holds its value, the tag pipe entry 0 captures {0,0}, and rr_ptr holds.
- Tag pipe:
  - Shift register of depth LATENCY, advanced every cycle (the unit never stalls).
  - Its last stage drives res_valid and res_id.
  - Result timing: handshake at cycle t gives u_valid at t+1 and res_valid at t+1+LATENCY. Throughput is 1 result per cycle.
- in_flight:
  - Counter of width clog2(LATENCY+2); +1 on transfer, -1 on res_valid, unchanged when both occur in the same cycle. It never exceeds LATENCY+1.
  - busy = (in_flight != 0).
- en deasserted mid-stream: no further grants; results already issued still appear at the normal cycles; busy falls after the last res_valid.
- A requester holding req_valid with changing data: whatever is on req_data in the handshake cycle is the value issued.
- A single persistent requester is granted every cycle: rr_ptr moves past it, but the search wraps back to it.

Test Plan:
- Reset then single request: LATENCY=4, unit modeled as a 4-cycle delay. req_valid=0001, req_data[0]=0x3F800000 (1.0f) at cycle t -> req_ready=0001 at t; u_valid=1 with u_in=0x3F800000 at t+1; res_valid=1, res_id=0, res_data=0x3F800000 at t+5; busy high from t+1 through t+5.
- Fairness: all four requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id sequence matches with no gaps; in_flight peaks at 5.
- Skip idle requesters: req_valid=1010 held, rr_ptr=0 -> grants 1,3,1,3; requesters 0 and 2 are never granted.
- Float stream from integers 0..9 via $to_float32 on requester 2 only -> ten back-to-back results 0x00000000, 0x3F800000, 0x40000000, 0x40400000, ... 0x41100000, in order, all with res_id=2.
- en dropped after 3 transfers while requests pending -> exactly 3 res_valid pulses, req_ready=0 while en=0; busy=0 one cycle after the last result; resuming en restarts from the saved rr_ptr.
- Async reset asserted mid-flight with 3 operations outstanding -> all outputs 0 immediately (before the next clk edge); no res_valid is produced afterwards for the discarded operations.
